regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=2); AW = clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have port Clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port rd_addr  input  NRD*AW  read addresses, port i at bits [i*AW +: AW].
REQ-007 SHALL have port rd_data  output  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN].
REQ-008 SHALL have port wen  input  1  writeback enable.
REQ-009 SHALL have port waddr  input  AW  writeback register index.
REQ-010 SHALL have port wdata  input  XLEN  writeback data.
REQ-011 SHALL have port iss_valid  input  1  issuing instruction present.
REQ-012 SHALL have port iss_dst_en  input  1  issuing instruction writes a destination.
REQ-013 SHALL have port iss_dst  input  AW  destination index of issuing instruction.
REQ-014 SHALL have port iss_ready  output  1  no hazard; issue accepted when iss_valid & iss_ready.
REQ-015 SHALL have port busy_cnt  output  AW+1  number of registers currently pending.

Function
REQ-016 SHALL read register 0 as zero on every port; writes to index 0 ignored, never marked pending.
REQ-017 SHALL read combinationally: rd_data[i] = reg[rd_addr[i]], zero latency.
REQ-018 SHALL write reg[waddr] <= wdata on rising edge when rst=1, wen=1, waddr!=0.
REQ-019 SHALL keep one pending bit per register (scoreboard); pending[0] constant 0.
REQ-020 SHALL clear pending[waddr] on edge when wen=1 and pending set.
REQ-021 SHALL set pending[iss_dst] on edge when iss_valid & iss_ready & iss_dst_en & iss_dst!=0.
REQ-022 SHALL give set priority over clear when both target the same index in one cycle (register stays pending).
REQ-023 SHALL drive iss_ready = 0 when any rd_addr[i]!=0 has effective pending, or iss_dst_en & iss_dst has effective pending (WAW); else 1, regardless of iss_valid.
REQ-024 SHALL define effective pending per REQ-033/034.
REQ-025 SHALL update busy_cnt by +1 on set, -1 on clear, 0 net when both occur on different indices or same index (REQ-022); never wraps (max NREG-1).
REQ-026 SHALL ignore wen to a non-pending register for scoreboard purposes (data still written, busy_cnt unchanged).

Reset
REQ-027 SHALL, on rising edge with rst=0, clear all registers to 0, all pending bits to 0, busy_cnt to 0.
REQ-028 SHALL give reset priority over simultaneous wen and issue; those are discarded.
REQ-029 SHALL, during reset, present rd_data = 0 after first reset edge and iss_ready = 1.
REQ-030 SHALL abandon pending state mid-operation on reset; no writeback after reset clears anything wrongly (busy_cnt stays 0).

Configuration
REQ-031 SHALL compile write-to-read bypass only when macro REGFILE_SB_BYPASS_EN is defined.
REQ-032 SHALL, with REGFILE_SB_BYPASS_EN, return wdata on port i when wen & waddr==rd_addr[i] & waddr!=0.
REQ-033 SHALL, with REGFILE_SB_BYPASS_EN, treat a register as not effectively pending when wen & waddr matches it this cycle.
REQ-034 SHALL, without the macro, return stored value and use raw pending bit (writeback-cycle read stalls one cycle).

Structure
REQ-035 SHALL place default XLEN/NREG/NRD and the clog2 helper function in shared package regfile_pkg.
REQ-036 SHALL implement the pending bits and busy_cnt in sub-module regfile_scoreboard; storage and read muxes in regfile_sb.

Verification
REQ-037 SHALL test reset: write r5=0xDEADBEEF, assert rst=0 one edge -> rd r5=0, busy_cnt=0, iss_ready=1.
REQ-038 SHALL test r0: wen, waddr=0, wdata=0xFFFFFFFF -> rd r0=0; issue dst=0 -> busy_cnt stays 0.
REQ-039 SHALL test RAW: issue dst=7, next cycle rd_addr[0]=7 -> iss_ready=0 until wen waddr=7 wdata=0x12; with bypass ready and rd_data=0x12 same cycle, without bypass ready next cycle.
REQ-040 SHALL test WAW: dst=3 pending, issue dst=3 -> iss_ready=0; busy_cnt=1.
REQ-041 SHALL test simultaneous: wen waddr=4 and accepted issue dst=4 same edge -> pending[4]=1, busy_cnt unchanged.
REQ-042 SHALL test fill: issue dst=1..NREG-1 -> busy_cnt=NREG-1; writeback all -> busy_cnt=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and the address-width helper for the scoreboarded register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits plus a running count of pending registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = clog2(NREG)
) (
  input  logic          Clk,
  input  logic          rst,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  output logic [NREG-1:0] pending,
  output logic [AW:0]   busy_cnt
);

  logic [NREG-1:0] pending_q, pending_d;
  logic [AW:0]     busy_cnt_q, busy_cnt_d;
  logic            do_clr;
  logic            do_set;

  always_comb begin
    do_clr = wen && (waddr != '0) && pending_q[waddr];
    // A set only adds to the count if the register ends up newly pending.
    do_set = set_en && (set_idx != '0) &&
             (!pending_q[set_idx] || (do_clr && (waddr == set_idx)));
    pending_d = pending_q;
    if (do_clr) pending_d[waddr] = 1'b0;
    if (set_en && (set_idx != '0)) pending_d[set_idx] = 1'b1;
    pending_d[0] = 1'b0;
    busy_cnt_d = busy_cnt_q + (AW+1)'(do_set) - (AW+1)'(do_clr);
  end

  always_ff @(posedge Clk) begin
    if (!rst) begin
      pending_q  <= '0;
      busy_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign pending  = pending_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with issue scoreboard; define REGFILE_SB_BYPASS_EN
// to forward same-cycle writeback data to reads and to the hazard check.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = NRD_DEF,
  localparam int AW   = clog2(NREG)
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic              wen,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              iss_valid,
  input  logic              iss_dst_en,
  input  logic [AW-1:0]     iss_dst,
  output logic              iss_ready,
  output logic [AW:0]       busy_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] eff_pend;
  logic            hazard;
  logic            set_en;

  always_comb begin
    regs_d = regs_q;
    if (wen && (waddr != '0)) regs_d[waddr] = wdata;
  end

  always_ff @(posedge Clk) begin
    if (!rst) regs_q <= '{default: '0};
    else      regs_q <= regs_d;
  end

  always_comb begin
    rd_data  = '0;
    eff_pend = pending;
`ifdef REGFILE_SB_BYPASS_EN
    if (rst && wen) eff_pend[waddr] = 1'b0;
`endif
    hazard = iss_dst_en && eff_pend[iss_dst];
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*AW +: AW] != '0) begin
        rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
`ifdef REGFILE_SB_BYPASS_EN
        if (rst && wen && (waddr == rd_addr[i*AW +: AW])) rd_data[i*XLEN +: XLEN] = wdata;
`endif
        if (eff_pend[rd_addr[i*AW +: AW]]) hazard = 1'b1;
      end
    end
    // Issue handshake: iss_ready depends only on hazards, never on iss_valid;
    // an instruction is taken on a rising edge where iss_valid && iss_ready.
    iss_ready = !rst || !hazard;
  end

  assign set_en = rst && iss_valid && iss_ready && iss_dst_en && (iss_dst != '0);

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .Clk      (Clk),
    .rst      (rst),
    .wen      (wen),
    .waddr    (waddr),
    .set_en   (set_en),
    .set_idx  (iss_dst),
    .pending  (pending),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with an array/count-based reference model.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                Clk = 1'b0;
  logic                rst = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic                wen = 1'b0;
  logic [AW-1:0]       waddr = '0;
  logic [XLEN-1:0]     wdata = '0;
  logic                iss_valid = 1'b0;
  logic                iss_dst_en = 1'b0;
  logic [AW-1:0]       iss_dst = '0;
  logic                iss_ready;
  logic [AW:0]         busy_cnt;

  int total = 0;
  int bad   = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .Clk        (Clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .iss_valid  (iss_valid),
    .iss_dst_en (iss_dst_en),
    .iss_dst    (iss_dst),
    .iss_ready  (iss_ready),
    .busy_cnt   (busy_cnt)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // reference model
  logic [XLEN-1:0] m_reg [NREG];
  bit              m_pend [NREG];
  bit              chk_en = 1'b0;

  function automatic bit m_eff(input int r);
    if (r == 0 || !m_pend[r]) return 1'b0;
    if (BYP && rst && wen && (int'(waddr) == r)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    if (!rst) return 1'b1;
    for (int p = 0; p < NRD; p++)
      if (m_eff(int'(rd_addr[p*AW +: AW]))) return 1'b0;
    if (iss_dst_en && m_eff(int'(iss_dst))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] m_rd(input int p);
    int a;
    a = int'(rd_addr[p*AW +: AW]);
    if (a == 0) return '0;
    if (BYP && rst && wen && (int'(waddr) == a)) return wdata;
    return m_reg[a];
  endfunction

  function automatic int m_busy();
    int n;
    n = 0;
    for (int r = 0; r < NREG; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  always @(posedge Clk) begin
    bit acc;
    acc = m_ready() && rst && iss_valid && iss_dst_en && (iss_dst != '0);
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_reg[r]  = '0;
        m_pend[r] = 1'b0;
      end
      chk_en = 1'b1;
    end else begin
      if (wen && waddr != '0) begin
        m_reg[waddr]  = wdata;
        m_pend[waddr] = 1'b0;
      end
      if (acc) m_pend[iss_dst] = 1'b1;
    end
  end

  // scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int p = 0; p < NRD; p++)
        chk($sformatf("model_rd%0d", p), 64'(rd_data[p*XLEN +: XLEN]), 64'(m_rd(p)));
      chk("model_ready", 64'(iss_ready), 64'(m_ready()));
      chk("model_busy", 64'(busy_cnt), 64'(m_busy()));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    wen = 1'b0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_dst_en = 1'b0; iss_dst = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic issue(input int d);
    iss_valid = 1'b1; iss_dst_en = 1'b1; iss_dst = AW'(d);
  endtask

  task automatic wb(input int a, input logic [XLEN-1:0] d);
    wen = 1'b1; waddr = AW'(a); wdata = d;
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    settle();
    chk("init_busy", 64'(busy_cnt), 64'd0);
    chk("init_ready", 64'(iss_ready), 64'd1);

    // reset clears stored data
    set_rd(0, 5); wb(5, 32'hDEADBEEF);
    tick(); idle(); settle();
    chk("r5_written", 64'(rd_data[31:0]), 64'hDEADBEEF);
    rst = 1'b0;
    tick(); settle();
    chk("rst_r5", 64'(rd_data[31:0]), 64'd0);
    chk("rst_busy", 64'(busy_cnt), 64'd0);
    chk("rst_ready", 64'(iss_ready), 64'd1);
    rst = 1'b1;

    // r0 is hardwired zero and never pending
    set_rd(0, 0); wb(0, 32'hFFFFFFFF); issue(0);
    tick(); idle(); settle();
    chk("r0_read", 64'(rd_data[31:0]), 64'd0);
    chk("r0_busy", 64'(busy_cnt), 64'd0);

    // RAW on r7
    issue(7); settle();
    chk("raw_ready_pre", 64'(iss_ready), 64'd1);
    tick(); idle(); set_rd(0, 7); settle();
    chk("raw_stall", 64'(iss_ready), 64'd0);
    chk("raw_busy", 64'(busy_cnt), 64'd1);
    tick(); settle();
    chk("raw_stall2", 64'(iss_ready), 64'd0);
    wb(7, 32'h12); settle();
    chk("raw_ready_wb", 64'(iss_ready), 64'(BYP));
    chk("raw_rd_wb", 64'(rd_data[31:0]), BYP ? 64'h12 : 64'h0);
    tick(); idle(); settle();
    chk("raw_ready_after", 64'(iss_ready), 64'd1);
    chk("raw_rd_after", 64'(rd_data[31:0]), 64'h12);
    chk("raw_busy_after", 64'(busy_cnt), 64'd0);

    // WAW on r3
    set_rd(0, 0); issue(3);
    tick(); settle();
    chk("waw_stall", 64'(iss_ready), 64'd0);
    chk("waw_busy", 64'(busy_cnt), 64'd1);
    tick(); idle(); settle();
    chk("waw_busy_hold", 64'(busy_cnt), 64'd1);

    // writeback and issue to r4 on one edge, r4 not pending
    wb(4, 32'h44); issue(4); settle();
    chk("sim_ready", 64'(iss_ready), 64'd1);
    tick(); idle(); set_rd(0, 4); settle();
    chk("sim_busy", 64'(busy_cnt), 64'd2);
    chk("sim_pending", 64'(iss_ready), 64'd0);
    chk("sim_data", 64'(rd_data[31:0]), 64'h44);

    // same again with r4 pending: bypass lets it issue, set wins over clear
    set_rd(0, 0); wb(4, 32'h55); issue(4); settle();
    chk("sim2_ready", 64'(iss_ready), 64'(BYP));
    tick(); idle(); set_rd(1, 4); settle();
    chk("sim2_busy", 64'(busy_cnt), BYP ? 64'd2 : 64'd1);
    chk("sim2_pending", 64'(iss_ready), BYP ? 64'd0 : 64'd1);
    chk("sim2_data", 64'(rd_data[63:32]), 64'h55);
    set_rd(1, 0); wb(3, 32'h33);
    tick(); wb(4, 32'h55);
    tick(); idle(); settle();
    chk("clean_busy", 64'(busy_cnt), 64'd0);

    // fill every register
    for (int i = 1; i < NREG; i++) begin
      issue(i);
      tick();
    end
    idle(); set_rd(0, 9); set_rd(1, 31); settle();
    chk("fill_busy", 64'(busy_cnt), 64'(NREG - 1));
    chk("fill_ready", 64'(iss_ready), 64'd0);
    for (int i = 1; i < NREG; i++) begin
      wb(i, 32'(i) * 32'h01010101);
      tick();
    end
    idle(); settle();
    chk("drain_busy", 64'(busy_cnt), 64'd0);
    chk("drain_ready", 64'(iss_ready), 64'd1);
    chk("drain_r9", 64'(rd_data[31:0]), 64'h09090909);
    chk("drain_r31", 64'(rd_data[63:32]), 64'h1F1F1F1F);

    // reset mid-operation discards writeback and issue
    set_rd(0, 0); set_rd(1, 0); issue(12);
    tick(); idle(); settle();
    chk("mid_busy", 64'(busy_cnt), 64'd1);
    rst = 1'b0; wb(12, 32'hAA); issue(13); settle();
    chk("mid_rst_ready", 64'(iss_ready), 64'd1);
    tick(); settle();
    chk("mid_rst_busy", 64'(busy_cnt), 64'd0);
    rst = 1'b1; idle(); wb(12, 32'hBB); set_rd(0, 12);
    tick(); idle(); settle();
    chk("post_rst_busy", 64'(busy_cnt), 64'd0);
    chk("post_rst_data", 64'(rd_data[31:0]), 64'hBB);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
